// File: rtl/fetch_redirect_ctrl.sv
// PC register and IF/ID pipeline register with JAL/JALR redirect and pcfreeze hold.
// Optional FETCH_STATS_EN adds the stall_cycles and redirect_cnt counters.
module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned MAX_HOLD  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pcfreeze,
  input  logic        jalr_id,
  input  logic        jal_id,
  input  logic [31:0] rs1_val,
  input  logic [11:0] jalr_imm,
  input  logic [20:0] jal_off,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        idex_bubble,
  output logic        hold_err
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] redirect_cnt
`endif
);

  localparam int unsigned CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {RUN, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] cnt_inc;
  logic          jalr_q, jal_q, frz_q;
  logic [31:0]   jalr_tgt, jal_tgt;

  assign jalr_q = jalr_id & ifid_valid;
  assign jal_q  = jal_id & ifid_valid;
  assign frz_q  = pcfreeze & ifid_valid;

  assign jalr_tgt    = (rs1_val + {{20{jalr_imm[11]}}, jalr_imm}) & ~32'd1;
  assign jal_tgt     = ifid_pc + {{11{jal_off[20]}}, jal_off};
  assign idex_bubble = frz_q;

  // Counter restarts at 1 on entry to HOLD and saturates at MAX_HOLD.
  always_comb begin
    cnt_inc = CW'(1);
    if (state == HOLD) begin
      cnt_inc = (hold_cnt == CW'(MAX_HOLD)) ? hold_cnt : hold_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      ifid_pc    <= '0;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
      hold_err   <= 1'b0;
      hold_cnt   <= '0;
      state      <= RUN;
    end else if (frz_q) begin
      state    <= HOLD;
      hold_cnt <= cnt_inc;
      if (cnt_inc == CW'(MAX_HOLD)) begin
        hold_err <= 1'b1;
      end
    end else begin
      state    <= RUN;
      hold_cnt <= '0;
      ifid_pc  <= pc;
      if (jalr_q || jal_q) begin
        // JALR wins over JAL if the decoder ever flags both.
        pc         <= jalr_q ? jalr_tgt : jal_tgt;
        ifid_instr <= NOP_INSTR;
        ifid_valid <= 1'b0;
      end else begin
        pc         <= pc + 32'd4;
        ifid_instr <= imem_instr;
        ifid_valid <= 1'b1;
      end
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      redirect_cnt <= '0;
    end else begin
      if (idex_bubble && stall_cycles != '1) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
      if (!frz_q && (jalr_q || jal_q) && redirect_cnt != '1) begin
        redirect_cnt <= redirect_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Scoreboard bench for fetch_redirect_ctrl: directed vectors push hand-computed
// expectations, a monitor pops and compares each cycle.
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, pcfreeze, jalr_id, jal_id;
  logic [31:0] rs1_val, imem_instr;
  logic [11:0] jalr_imm;
  logic [20:0] jal_off;
  logic [31:0] pc, ifid_pc, ifid_instr;
  logic        ifid_valid, idex_bubble, hold_err;
`ifdef FETCH_STATS_EN
  logic [15:0] stall_cycles, redirect_cnt;
`endif

  fetch_redirect_ctrl #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013),
    .MAX_HOLD (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pcfreeze   (pcfreeze),
    .jalr_id    (jalr_id),
    .jal_id     (jal_id),
    .rs1_val    (rs1_val),
    .jalr_imm   (jalr_imm),
    .jal_off    (jal_off),
    .imem_instr (imem_instr),
    .pc         (pc),
    .ifid_pc    (ifid_pc),
    .ifid_instr (ifid_instr),
    .ifid_valid (ifid_valid),
    .idex_bubble(idex_bubble),
    .hold_err   (hold_err)
`ifdef FETCH_STATS_EN
    ,
    .stall_cycles(stall_cycles),
    .redirect_cnt(redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        bub;
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic [31:0] ifi;
    logic        v;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errs    = 0;
  int   checked = 0;

  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      errs++;
      $display("FAIL %s vec%0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  // Apply one cycle of stimulus and queue the expected post-edge state.
  task automatic vec(input logic r, input logic frz, input logic jr, input logic j,
                     input logic [31:0] rs1, input logic [11:0] imm, input logic [20:0] off,
                     input logic [31:0] instr, input logic eb, input logic [31:0] epc,
                     input logic [31:0] eifpc, input logic [31:0] eifi, input logic ev,
                     input logic eerr);
    exp_t e;
    @(negedge clk);
    rst_n = r; pcfreeze = frz; jalr_id = jr; jal_id = j;
    rs1_val = rs1; jalr_imm = imm; jal_off = off; imem_instr = instr;
    #1;
    vectors++;
    e.id = vectors; e.bub = eb; e.pc = epc; e.ifpc = eifpc; e.ifi = eifi; e.v = ev; e.err = eerr;
    q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (checked < vectors && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (checked < vectors) begin
      errs++;
      $display("FAIL drain_timeout: checked %0d expected %0d", checked, vectors);
    end
  endtask

  initial begin : monitor
    exp_t e;
    logic b;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        b = idex_bubble;
        @(posedge clk);
        #1;
        chk("idex_bubble", e.id, {31'd0, b}, {31'd0, e.bub});
        chk("pc", e.id, pc, e.pc);
        chk("ifid_pc", e.id, ifid_pc, e.ifpc);
        chk("ifid_instr", e.id, ifid_instr, e.ifi);
        chk("ifid_valid", e.id, {31'd0, ifid_valid}, {31'd0, e.v});
        chk("hold_err", e.id, {31'd0, hold_err}, {31'd0, e.err});
        checked++;
      end
    end
  end

  initial begin : stim
    //   rst frz jr j  rs1           imm      off      instr        bub pc            ifid_pc       ifid_instr    v  err
    vec(0, 0, 0, 0, 32'h0,        12'h000, 21'h0,  32'h0,        0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0013, 0, 0);
    // free-running fetch
    vec(1, 0, 0, 0, 32'h0,        12'h000, 21'h0,  32'hA000_0000, 0, 32'h0000_0004, 32'h0000_0000, 32'hA000_0000, 1, 0);
    vec(1, 0, 0, 0, 32'h0,        12'h000, 21'h0,  32'hA000_0004, 0, 32'h0000_0008, 32'h0000_0004, 32'hA000_0004, 1, 0);
    vec(1, 0, 0, 0, 32'h0,        12'h000, 21'h0,  32'hA000_0008, 0, 32'h0000_000C, 32'h0000_0008, 32'hA000_0008, 1, 0);
    vec(1, 0, 0, 0, 32'h0,        12'h000, 21'h0,  32'hA000_000C, 0, 32'h0000_0010, 32'h0000_000C, 32'hA000_000C, 1, 0);
    vec(1, 0, 0, 0, 32'h0,        12'h000, 21'h0,  32'hA000_0010, 0, 32'h0000_0014, 32'h0000_0010, 32'hA000_0010, 1, 0);
    // JAL at ifid_pc 0x10, offset 0x40
    vec(1, 0, 0, 1, 32'h0,        12'h000, 21'h40, BAD,          0, 32'h0000_0050, 32'h0000_0014, 32'h0000_0013, 0, 0);
    // freeze against squashed slot is ignored
    vec(1, 1, 0, 0, 32'h0,        12'h000, 21'h0,  32'hA000_0050, 0, 32'h0000_0054, 32'h0000_0050, 32'hA000_0050, 1, 0);
    // JALR frozen 2 cycles, then resolves to 0x1000 (JAL also flagged: JALR wins)
    vec(1, 1, 1, 0, 32'h0000_0777, 12'hFFF, 21'h0,  BAD,          1, 32'h0000_0054, 32'h0000_0050, 32'hA000_0050, 1, 0);
    vec(1, 1, 1, 0, 32'h0000_0777, 12'hFFF, 21'h0,  BAD,          1, 32'h0000_0054, 32'h0000_0050, 32'hA000_0050, 1, 0);
    vec(1, 0, 1, 1, 32'h0000_1001, 12'hFFF, 21'h40, BAD,          0, 32'h0000_1000, 32'h0000_0054, 32'h0000_0013, 0, 0);
    // stale jalr_id against squashed slot is ignored
    vec(1, 0, 1, 0, 32'h0000_5555, 12'h000, 21'h0,  32'hA000_1000, 0, 32'h0000_1004, 32'h0000_1000, 32'hA000_1000, 1, 0);
    // 8 freeze cycles -> hold_err on the 8th
    for (int i = 0; i < 8; i++) begin
      vec(1, 1, 0, 0, 32'h0, 12'h000, 21'h0, BAD, 1, 32'h0000_1004, 32'h0000_1000, 32'hA000_1000, 1, (i == 7));
    end
    vec(1, 0, 0, 0, 32'h0,        12'h000, 21'h0,  32'hA000_1004, 0, 32'h0000_1008, 32'h0000_1004, 32'hA000_1004, 1, 1);
    vec(1, 1, 0, 0, 32'h0,        12'h000, 21'h0,  BAD,          1, 32'h0000_1008, 32'h0000_1004, 32'hA000_1004, 1, 1);
    drain();
`ifdef FETCH_STATS_EN
    chk("stall_cycles", vectors, {16'd0, stall_cycles}, 32'd11);
    chk("redirect_cnt", vectors, {16'd0, redirect_cnt}, 32'd2);
`endif
    // reset mid-HOLD
    vec(0, 1, 0, 0, 32'h0,        12'h000, 21'h0,  BAD,          1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0013, 0, 0);
    vec(1, 0, 0, 0, 32'h0,        12'h000, 21'h0,  32'hA000_0000, 0, 32'h0000_0004, 32'h0000_0000, 32'hA000_0000, 1, 0);
    // JALR target wrap
    vec(1, 0, 1, 0, 32'hFFFF_FFF0, 12'h020, 21'h0,  BAD,          0, 32'h0000_0010, 32'h0000_0004, 32'h0000_0013, 0, 0);
    vec(1, 0, 0, 0, 32'h0,        12'h000, 21'h0,  32'hA000_0010, 0, 32'h0000_0014, 32'h0000_0010, 32'hA000_0010, 1, 0);
    // JALR to 0xFFFFFFFC (low bit cleared), then pc increment wraps to 0
    vec(1, 0, 1, 0, 32'hFFFF_FFFD, 12'hFFF, 21'h0,  BAD,          0, 32'hFFFF_FFFC, 32'h0000_0014, 32'h0000_0013, 0, 0);
    vec(1, 0, 0, 0, 32'h0,        12'h000, 21'h0,  32'hA000_FFFC, 0, 32'h0000_0000, 32'hFFFF_FFFC, 32'hA000_FFFC, 1, 0);
    drain();
`ifdef FETCH_STATS_EN
    chk("stall_cycles_after_reset", vectors, {16'd0, stall_cycles}, 32'd0);
    chk("redirect_cnt_after_reset", vectors, {16'd0, redirect_cnt}, 32'd2);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Consumer end of the JALR/JAL hazard interface.
- Owns the PC register and the IF/ID pipeline register of the 5-stage core.
- Acts on `pcfreeze` from the jalr hazard handler by holding PC and IF/ID and bubbling ID/EX.
- Redirects fetch to JAL/JALR targets, computed from the forwarded rs1 value (output of the rv1 mux), and squashes the wrong-path instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- NOP_INSTR, 32'h0000_0013, instruction injected into IF/ID on squash (addi x0,x0,0).
- MAX_HOLD, 8, consecutive HOLD cycles after which `hold_err` sets.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- pcfreeze  in  1  stall request from jalr hazard handler
- jalr_id  in  1  instruction in IF/ID is JALR (from decoder)
- jal_id  in  1  instruction in IF/ID is JAL
- rs1_val  in  32  forwarded rs1 value (after rv1 mux)
- jalr_imm  in  12  I-type immediate of IF/ID instruction
- jal_off  in  21  J-type offset (bit0 = 0) of IF/ID instruction
- imem_instr  in  32  instruction memory data for address `pc`
- pc  out  32  current fetch address (to imem)
- ifid_pc  out  32  PC of instruction in IF/ID
- ifid_instr  out  32  IF/ID instruction
- ifid_valid  out  1  IF/ID holds a real instruction
- idex_bubble  out  1  load NOP into ID/EX this cycle (combinational)
- hold_err  out  1  sticky: HOLD exceeded MAX_HOLD

Behaviour:

Clocking and reset:
- All state updates on posedge clk.
- rst_n=0 sampled at an edge sets `pc`=RESET_PC, `ifid_pc`=0, `ifid_instr`=NOP_INSTR, `ifid_valid`=0, `hold_err`=0, hold counter=0, state=RUN.
- Reset overrides any freeze or redirect in progress; no partial update survives it.

Qualification:
- `jalr_q` = `jalr_id` & `ifid_valid`; `jal_q` = `jal_id` & `ifid_valid`; `frz_q` = `pcfreeze` & `ifid_valid`.
- Freeze or jump indications against a squashed slot are ignored.

Target arithmetic (mod 2^32, wrap-around silent):
- `jalr_tgt` = (`rs1_val` + sext32(`jalr_imm`)) & ~1.
- `jal_tgt` = `ifid_pc` + sext32(`jal_off`).

Priority per cycle: `frz_q` > `jalr_q` > `jal_q` > sequential.

- **Freeze** (`frz_q`=1): `pc`, `ifid_*` held. `idex_bubble`=1 in the same cycle. State->HOLD. Hold counter +1, saturating at MAX_HOLD.
- **Redirect** (`jalr_q` or `jal_q`, no freeze): `pc`<=target; `ifid_instr`<=NOP_INSTR, `ifid_valid`<=0, `ifid_pc`<=`pc` (squash wrong-path fetch). `idex_bubble`=0; the jump itself proceeds to EX for link write. State->RUN, counter cleared.
- **Sequential**: `pc`<=`pc`+4; `ifid_pc`<=`pc`; `ifid_instr`<=`imem_instr`; `ifid_valid`<=1. State->RUN, counter cleared.
- `idex_bubble` = `frz_q`, combinational; 0 otherwise.

FSM:
- RUN -> HOLD on `frz_q`.
- HOLD -> HOLD while `frz_q`.
- HOLD -> RUN on `frz_q`=0. The same cycle performs the JALR redirect using `rs1_val`, now forwarded from EX/MEM.
- Latency: redirect target appears on `pc` one cycle after the resolving edge. Each JALR costs 1 squash cycle plus N freeze cycles.
- `hold_err` sets when the hold counter reaches MAX_HOLD while still in HOLD. It clears only on reset.
- `pc` increment wraps 32'hFFFF_FFFC -> 0.
- `jal_q` and `jalr_q` both 1 (decoder fault): JALR wins.

Optional Feature:
Macro FETCH_STATS_EN.
- Defined: adds outputs `stall_cycles` [15:0] (+1 per cycle `idex_bubble`=1) and `redirect_cnt` [15:0] (+1 per redirect). Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
1. Reset then 4 free-running cycles with `imem_instr`=`pc`-tag -> `pc` 0,4,8,C,10; `ifid_valid` rises after 1st edge; `ifid_pc` lags `pc` by one cycle.
2. JAL at `ifid_pc`=0x10, `jal_off`=0x40 -> next `pc`=0x50, `ifid_instr`=0x13, `ifid_valid`=0, `idex_bubble` stays 0.
3. JALR, `rs1_val`=0x1001, `jalr_imm`=0xFFF, `pcfreeze`=1 for 2 cycles -> `pc`/`ifid` held 2 cycles, `idex_bubble`=1 both; then `pc`=0x1000 and squash.
4. `pcfreeze`=1 with `ifid_valid`=0 -> ignored: `pc` advances by 4, `idex_bubble`=0.
5. `pcfreeze` held 8 cycles (MAX_HOLD=8) -> `hold_err`=1 and stays 1 after release; rst_n=0 asserted mid-HOLD -> `pc`=RESET_PC, `hold_err`=0, `ifid_valid`=0 next cycle.
6. `jalr_tgt` wrap: `rs1_val`=0xFFFF_FFF0, `jalr_imm`=0x020 -> `pc`=0x0000_0010; with FETCH_STATS_EN, `redirect_cnt` increments by 1.
